// File: rtl/emg_seq_pkg.sv
// Shared definitions for the EMG channel sequencer: FSM encoding, the legacy
// dwell value, and the channel-select width helper.
package emg_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } seq_state_t;

    // Dwell of the original fixed sequencer (14 cycles per channel).
    localparam int LEGACY_DWELL = 13;

    // Channel-select width: max(1, clog2(n)).
    function automatic int ch_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/emg_next_ch.sv
// Combinational channel finder. Returns the next set mask bit above the
// current index, a wrap flag when none exists, and the lowest set bit.
module emg_next_ch
    import emg_seq_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    output logic [CH_W-1:0]   next_ch,
    output logic              wrap,
    output logic [CH_W-1:0]   lowest_ch,
    output logic              any
);

    logic found;

    // Scan from the top down so the last hit is the lowest qualifying index.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise a path
        // with no assignment would infer a latch.
        next_ch   = '0;
        lowest_ch = '0;
        any       = 1'b0;
        found     = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_ch = CH_W'(i);
                any       = 1'b1;
                if (i > int'(cur)) begin
                    next_ch = CH_W'(i);
                    found   = 1'b1;
                end
            end
        end
        wrap = !found;
    end

endmodule

// File: rtl/emg_channel_sequencer.sv
// Channel-select sequencer for the EMG front-end: steps through the set bits
// of a channel mask with a programmable dwell, in continuous or single-shot
// mode, and emits a toggling start, a start strobe and a pass-done strobe.
module emg_channel_sequencer
    import emg_seq_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int CH_W    = ch_width(NUM_CH),
    parameter int DWELL_W = 8
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic               en,
    input  logic               single_shot,
    input  logic [DWELL_W-1:0] dwell_cfg,
    input  logic [NUM_CH-1:0]  ch_mask,
    output logic [CH_W-1:0]    CH_Sel,
    output logic               start,
    output logic               start_pulse,
    output logic               scan_done,
    output logic               busy
);

    seq_state_t         state, state_d;
    logic [DWELL_W-1:0] counter, counter_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               single_q, single_d;
    logic [CH_W-1:0]    ch_d;
    logic               start_d, pulse_d, done_d, busy_d;

    logic [CH_W-1:0]    step_ch;
    logic               step_wrap;
    logic [CH_W-1:0]    load_ch;
    logic               load_any;
    logic [CH_W-1:0]    unused_step_lowest;
    logic               unused_step_any;
    logic [CH_W-1:0]    unused_load_next;
    logic               unused_load_wrap;

    logic expiry;
    assign expiry = (counter == dwell_q);

    // Stepping works on the latched mask so mid-pass edits cannot disturb it.
    emg_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_step (
        .mask      (mask_q),
        .cur       (CH_Sel),
        .next_ch   (step_ch),
        .wrap      (step_wrap),
        .lowest_ch (unused_step_lowest),
        .any       (unused_step_any)
    );

    // The live mask decides where a new pass (start or wrap) begins.
    emg_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_load (
        .mask      (ch_mask),
        .cur       ({CH_W{1'b0}}),
        .next_ch   (unused_load_next),
        .wrap      (unused_load_wrap),
        .lowest_ch (load_ch),
        .any       (load_any)
    );

    // State, counter, latched configuration and all outputs are registered.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            counter     <= '0;
            dwell_q     <= '0;
            mask_q      <= '0;
            single_q    <= 1'b0;
            CH_Sel      <= '0;
            start       <= 1'b0;
            start_pulse <= 1'b0;
            scan_done   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state       <= state_d;
            counter     <= counter_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            single_q    <= single_d;
            CH_Sel      <= ch_d;
            start       <= start_d;
            start_pulse <= pulse_d;
            scan_done   <= done_d;
            busy        <= busy_d;
        end
    end

    // Next-state and next-output logic; holds everything unless an event fires.
    always_comb begin
        state_d   = state;
        counter_d = counter;
        dwell_d   = dwell_q;
        mask_d    = mask_q;
        single_d  = single_q;
        ch_d      = CH_Sel;
        start_d   = start;
        pulse_d   = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy;

        unique case (state)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (en && load_any) begin
                    state_d   = ST_SCAN;
                    mask_d    = ch_mask;
                    dwell_d   = dwell_cfg;
                    single_d  = single_shot;
                    ch_d      = load_ch;
                    counter_d = '0;
                    start_d   = ~start;
                    pulse_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    ch_d      = '0;
                    counter_d = '0;
                end else if (!expiry) begin
                    counter_d = counter + DWELL_W'(1);
                end else begin
                    counter_d = '0;
                    if (!step_wrap) begin
                        ch_d    = step_ch;
                        start_d = ~start;
                        pulse_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        // An empty mask at the wrap point ends the scan like single-shot.
                        if (single_q || !load_any) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            mask_d  = ch_mask;
                            dwell_d = dwell_cfg;
                            ch_d    = load_ch;
                            start_d = ~start;
                            pulse_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_emg_channel_sequencer.sv
// Self-checking bench for emg_channel_sequencer: a 16-channel instance and a
// 5-channel instance, expected channel steps queued up front and compared as
// the DUT strobes start_pulse.
module tb_emg_channel_sequencer;
    import emg_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset_n;

    logic        en, single_shot;
    logic [7:0]  dwell_cfg;
    logic [15:0] ch_mask;
    logic [3:0]  CH_Sel;
    logic        start, start_pulse, scan_done, busy;

    logic        en5, single5;
    logic [7:0]  dwell5;
    logic [4:0]  mask5;
    logic [2:0]  ch5;
    logic        start5, pulse5, done5, busy5;

    emg_channel_sequencer #(.NUM_CH(16), .DWELL_W(8)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .en(en), .single_shot(single_shot),
        .dwell_cfg(dwell_cfg), .ch_mask(ch_mask), .CH_Sel(CH_Sel),
        .start(start), .start_pulse(start_pulse), .scan_done(scan_done), .busy(busy)
    );

    emg_channel_sequencer #(.NUM_CH(5), .DWELL_W(8)) dut5 (
        .CLK(CLK), .Reset_n(Reset_n), .en(en5), .single_shot(single5),
        .dwell_cfg(dwell5), .ch_mask(mask5), .CH_Sel(ch5),
        .start(start5), .start_pulse(pulse5), .scan_done(done5), .busy(busy5)
    );

    always #5 CLK = ~CLK;

    // Observation mux: which instance the step checker is watching.
    logic       sel5 = 1'b0;
    logic [3:0] obs_ch;
    logic       obs_pulse, obs_done, obs_start;
    always_comb begin
        obs_ch    = sel5 ? {1'b0, ch5} : CH_Sel;
        obs_pulse = sel5 ? pulse5 : start_pulse;
        obs_done  = sel5 ? done5  : scan_done;
        obs_start = sel5 ? start5 : start;
    end

    int max_ch5 = 0;
    always @(negedge CLK) if (int'(ch5) > max_ch5) max_ch5 <= int'(ch5);

    typedef struct {
        logic [3:0] ch;
        int         gap;
        logic       done;
    } step_t;

    step_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    since    = 0;
    logic  exp_start [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    task automatic push(input logic [3:0] ch, input int gap, input logic done);
        step_t s;
        s.ch = ch; s.gap = gap; s.done = done;
        exp_q.push_back(s);
    endtask

    // Pop each expected step and compare when the DUT strobes start_pulse.
    task automatic expect_steps(input string tag);
        step_t e;
        int    wait_cyc;
        int    idx;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_cyc = 0;
            do begin
                @(negedge CLK);
                since++;
                wait_cyc++;
            end while (!obs_pulse && wait_cyc < 400);
            if (!obs_pulse) begin
                check({tag, "_timeout"}, obs_pulse, 1'b1);
                exp_q.delete();
                return;
            end
            idx = sel5 ? 1 : 0;
            exp_start[idx] = ~exp_start[idx];
            check({tag, "_ch"},    obs_ch,    e.ch);
            check({tag, "_gap"},   since,     e.gap);
            check({tag, "_done"},  obs_done,  e.done);
            check({tag, "_start"}, obs_start, exp_start[idx]);
            since = 0;
        end
    endtask

    // Call at a negedge: drop en, then one edge later expect a quiet IDLE.
    task automatic abort_check(input string tag);
        en = 1'b0;
        @(negedge CLK);
        check({tag, "_busy"},  busy,        1'b0);
        check({tag, "_ch"},    CH_Sel,      4'd0);
        check({tag, "_start"}, start,       exp_start[0]);
        check({tag, "_pulse"}, start_pulse, 1'b0);
    endtask

    task automatic begin_scan(input logic [15:0] m, input logic [7:0] d, input logic ss);
        ch_mask = m; dwell_cfg = d; single_shot = ss; en = 1'b1;
        since = 0;
    endtask

    initial begin
        int act;
        int wait_cyc;

        Reset_n = 1'b0;
        en = 1'b0; single_shot = 1'b0; dwell_cfg = '0; ch_mask = '0;
        en5 = 1'b0; single5 = 1'b0; dwell5 = '0; mask5 = '0;
        exp_start[0] = 1'b0;
        exp_start[1] = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_ch",    CH_Sel,      4'd0);
        check("rst_start", start,       1'b0);
        check("rst_pulse", start_pulse, 1'b0);
        check("rst_done",  scan_done,   1'b0);
        check("rst_busy",  busy,        1'b0);
        Reset_n = 1'b1;
        @(negedge CLK);

        // Legacy: all 16 channels, 14 cycles each, done on the 15->0 wrap.
        begin_scan(16'hFFFF, 8'(LEGACY_DWELL), 1'b0);
        push(4'd0, 1, 1'b0);
        for (int i = 1; i < 16; i++) push(4'(i), LEGACY_DWELL + 1, 1'b0);
        push(4'd0, LEGACY_DWELL + 1, 1'b1);
        push(4'd1, LEGACY_DWELL + 1, 1'b0);
        expect_steps("legacy");
        abort_check("legacy_abort");

        // Sparse single-shot: 0,2,5,11 then done, busy falls, CH_Sel holds 11.
        begin_scan(16'h0825, 8'd2, 1'b1);
        push(4'd0, 1, 1'b0);
        push(4'd2, 3, 1'b0);
        push(4'd5, 3, 1'b0);
        push(4'd11, 3, 1'b0);
        expect_steps("sparse");
        wait_cyc = 0;
        do begin
            @(negedge CLK);
            since++;
            wait_cyc++;
        end while (!scan_done && wait_cyc < 50);
        check("sparse_done_seen", scan_done,   1'b1);
        check("sparse_done_gap",  since,       3);
        check("sparse_busy",      busy,        1'b0);
        check("sparse_hold_ch",   CH_Sel,      4'd11);
        check("sparse_no_pulse",  start_pulse, 1'b0);
        check("sparse_start",     start,       exp_start[0]);
        en = 1'b0;
        @(negedge CLK);
        check("sparse_idle_ch",   CH_Sel,      4'd11);
        check("sparse_idle_busy", busy,        1'b0);
        check("sparse_idle_done", scan_done,   1'b0);

        // dwell_cfg=0: a new channel every cycle.
        begin_scan(16'h0007, 8'd0, 1'b0);
        push(4'd0, 1, 1'b0);
        push(4'd1, 1, 1'b0);
        push(4'd2, 1, 1'b0);
        push(4'd0, 1, 1'b1);
        push(4'd1, 1, 1'b0);
        expect_steps("dwell0");
        abort_check("dwell0_abort");

        // Empty mask with en=1: nothing happens.
        begin_scan(16'h0000, 8'd3, 1'b0);
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (busy || start_pulse || scan_done || (start !== exp_start[0])) act++;
        end
        check("mask0_activity", act,   0);
        check("mask0_busy",     busy,  1'b0);
        check("mask0_start",    start, exp_start[0]);
        en = 1'b0;

        // Single-bit continuous: CH_Sel stays 8, done with every dwell.
        begin_scan(16'h0100, 8'd4, 1'b0);
        push(4'd8, 1, 1'b0);
        push(4'd8, 5, 1'b1);
        push(4'd8, 5, 1'b1);
        expect_steps("single_bit");
        abort_check("single_bit_abort");

        // Abort mid-dwell on channel 6.
        begin_scan(16'hFFFF, 8'd3, 1'b0);
        push(4'd0, 1, 1'b0);
        for (int i = 1; i <= 6; i++) push(4'(i), 4, 1'b0);
        expect_steps("abort");
        @(negedge CLK);
        abort_check("abort_ch6");

        // Asynchronous reset mid-scan, between clock edges.
        begin_scan(16'hFFFF, 8'd5, 1'b0);
        push(4'd0, 1, 1'b0);
        push(4'd1, 6, 1'b0);
        expect_steps("rst_scan");
        @(negedge CLK);
        #1 Reset_n = 1'b0;
        #1;
        check("async_rst_ch",    CH_Sel,      4'd0);
        check("async_rst_start", start,       1'b0);
        check("async_rst_pulse", start_pulse, 1'b0);
        check("async_rst_done",  scan_done,   1'b0);
        check("async_rst_busy",  busy,        1'b0);
        exp_start[0] = 1'b0;
        en = 1'b0;
        @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
        check("post_rst_busy", busy, 1'b0);

        // Mask edited mid-pass: the pass finishes on the old mask, wrap uses the new one.
        begin_scan(16'h000F, 8'd1, 1'b0);
        push(4'd0, 1, 1'b0);
        push(4'd1, 2, 1'b0);
        expect_steps("cfg_a");
        ch_mask = 16'h00F0;
        push(4'd2, 2, 1'b0);
        push(4'd3, 2, 1'b0);
        push(4'd4, 2, 1'b1);
        push(4'd5, 2, 1'b0);
        expect_steps("cfg_b");
        abort_check("cfg_abort");

        // Five-channel build: 0..4, wrap, never above 4.
        sel5 = 1'b1;
        mask5 = 5'h1F; dwell5 = 8'd1; single5 = 1'b0; en5 = 1'b1;
        since = 0;
        push(4'd0, 1, 1'b0);
        for (int i = 1; i < 5; i++) push(4'(i), 2, 1'b0);
        push(4'd0, 2, 1'b1);
        push(4'd1, 2, 1'b0);
        expect_steps("nch5");
        check("nch5_range", (max_ch5 <= 4), 1'b1);
        en5 = 1'b0;
        @(negedge CLK);
        check("nch5_abort_busy", busy5, 1'b0);
        check("nch5_abort_ch",   ch5,   3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
